// File: rtl/calc_pkg.sv
// Shared constants for the calculator display path: BCD digit width and
// active-low {g,f,e,d,c,b,a} seven-segment patterns.
package calc_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    // Non-decimal codes 10-15 render blank rather than hex glyphs.
    function automatic logic [6:0] seg7_of(input logic [BCD_W-1:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder with a
// blank override.
module bcd_to_seg7
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             blank,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank)
            seg = seg7_of(digit);
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Double-buffered multiplexed seven-segment scanner for a packed-BCD result.
// Define SEG_LZB_EN to blank leading zeros above the most-significant digit.
module bcd_seg_scan
    import calc_pkg::*;
#(
    parameter int IN_DIGITS  = 10,
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bcd_valid,
    input  logic [BCD_W*IN_DIGITS-1:0] bcd_digits,
    output logic                       bcd_ready,
    output logic [NUM_DIGITS-1:0]      an,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic                       frame_tick
);

    localparam int PS_W  = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PS_W-1:0]              prescaler;
    logic [IDX_W-1:0]             idx;
    logic                         started;
    logic                         pend_full;
    logic [BCD_W*IN_DIGITS-1:0]   pending;
    logic [BCD_W*IN_DIGITS-1:0]   shadow;
    logic [NUM_DIGITS-1:0][6:0]   dec_seg;
    logic [NUM_DIGITS-1:0][6:0]   seg_arr;
    logic                         overflow;
    logic                         scan_wrap;
    logic                         last_digit;
    logic                         boundary;
    logic                         accept;

    assign scan_wrap  = (prescaler == PS_W'(SCAN_DIV - 1));
    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign boundary   = scan_wrap && last_digit;
    assign accept     = bcd_valid && !pend_full;
    assign bcd_ready  = !pend_full;
    assign dp         = 1'b1;

    // Any non-zero digit that has no physical position means the value cannot be shown.
    always_comb begin
        overflow = 1'b0;
        for (int k = NUM_DIGITS; k < IN_DIGITS; k++)
            overflow = overflow | (shadow[k*BCD_W +: BCD_W] != '0);
    end

`ifdef SEG_LZB_EN
    logic [IDX_W-1:0] msd;

    // Digit 0 is the floor so a zero value still shows a single "0".
    always_comb begin
        msd = '0;
        for (int k = 1; k < NUM_DIGITS; k++)
            if (shadow[k*BCD_W +: BCD_W] != '0)
                msd = IDX_W'(k);
    end
`endif

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
        logic blank;
`ifdef SEG_LZB_EN
        assign blank = (IDX_W'(d) > msd);
`else
        assign blank = 1'b0;
`endif
        bcd_to_seg7 u_dec (
            .digit (shadow[d*BCD_W +: BCD_W]),
            .blank (blank),
            .seg   (dec_seg[d])
        );
        assign seg_arr[d] = overflow ? SEG_DASH : dec_seg[d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler  <= '0;
            idx        <= '0;
            started    <= 1'b0;
            pend_full  <= 1'b0;
            pending    <= '0;
            shadow     <= '0;
            frame_tick <= 1'b0;
            an         <= '1;
            seg        <= SEG_BLANK;
        end else begin
            prescaler  <= scan_wrap ? '0 : prescaler + 1'b1;
            frame_tick <= boundary;
            if (scan_wrap) begin
                started <= 1'b1;
                idx     <= last_digit ? '0 : idx + 1'b1;
            end
            // Accept needs an empty pending slot and transfer needs a full one, so they never collide.
            if (accept) begin
                pending   <= bcd_digits;
                pend_full <= 1'b1;
            end else if (boundary && pend_full) begin
                shadow    <= pending;
                pend_full <= 1'b0;
            end
            // Stay dark until the first scan step so the bank never flashes digit 0 out of reset.
            an  <= started ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg <= started ? seg_arr[idx] : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan (SCAN_DIV=4, 8 of 10 digits); expectations
// follow SEG_LZB_EN when it is defined for the build.
module tb_bcd_seg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bcd_valid;
    logic [39:0] bcd_digits;
    logic        bcd_ready;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    typedef struct {
        logic [39:0] v;
        int          acc;
    } pend_t;

    pend_t       pq[$];
    logic [39:0] disp_val;
    logic [7:0]  ea;
    logic [7:0]  one8 = 8'h01;
    int          k;
    bit          mon_en;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          a_k, b_k;

    bcd_seg_scan #(.IN_DIGITS(10), .NUM_DIGITS(8), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_valid  (bcd_valid),
        .bcd_digits (bcd_digits),
        .bcd_ready  (bcd_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    endtask

    function automatic logic [6:0] exp_seg(input logic [39:0] v, input int d);
        int         top;
        logic [3:0] c;
        if (v[39:32] != 8'h00) return 7'h3F;
        top = 0;
        for (int i = 0; i < 8; i++)
            if (v[4*i +: 4] != 4'h0) top = i;
        c = v[4*d +: 4];
`ifdef SEG_LZB_EN
        if (d > top) return 7'h7F;
`endif
        case (c)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always @(posedge clk) if (mon_en) k++;

    // Independent scan model: k edges since reset release fixes the lit digit and frame phase.
    always @(negedge clk) if (mon_en) begin
        ea = (k < 5) ? 8'hFF : ~(one8 << (((k - 1) / 4) % 8));
        chk("an", an, ea);
        chk("frame_tick", frame_tick, (k > 0 && k % 32 == 0));
        chk("dp", dp, 1);
        if (ea == 8'hFF) chk("seg_idle", seg, 7'h7F);
        else             chk("seg", seg, exp_seg(disp_val, ((k - 1) / 4) % 8));
        if (k > 0 && k % 32 == 0 && pq.size() != 0 && pq[0].acc < k)
            disp_val = pq.pop_front().v;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0; mon_en = 1'b0; bcd_valid = 1'b0;
        repeat (cycles) tick();
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_ready", bcd_ready, 1);
        chk("rst_tick", frame_tick, 0);
        chk("rst_dp", dp, 1);
        rst_n = 1'b1; pq.delete(); disp_val = '0; k = 0; mon_en = 1'b1;
    endtask

    task automatic load(input logic [39:0] v, output int acc_k);
        int n = 0;
        bcd_valid = 1'b1; bcd_digits = v;
        while (!bcd_ready && n < 300) begin tick(); n++; end
        if (n >= 300) chk("accept_timeout", n, 0);
        tick();
        acc_k = k;
        pq.push_back('{v, k});
        bcd_valid = 1'b0; bcd_digits = 40'hFF_FFFF_FFFF;
        chk("ready_drop", bcd_ready, 0);
    endtask

    task automatic wait_frames(input int n);
        int seen = 0, t = 0;
        while (seen < n && t < n * 32 + 64) begin
            tick(); t++;
            if (frame_tick) seen++;
        end
        if (seen < n) chk("frame_timeout", seen, n);
    endtask

    initial begin
        rst_n = 1'b0; bcd_valid = 1'b0; bcd_digits = '0;
        mon_en = 1'b0; k = 0; disp_val = '0;
        tick();
        do_reset(3);
        wait_frames(1);

        load(40'h00_0001_2345, a_k);
        wait_frames(2);

        load(40'h10_0000_0000, a_k);
        wait_frames(2);
        load(40'h00_0000_0000, a_k);
        wait_frames(2);

        load(40'h00_9876_5432, a_k);
        chk("a_after_boundary", (a_k - 1) % 32, 0);
        load(40'h00_0000_0078, b_k);
        chk("b_after_boundary", (b_k - 1) % 32, 0);
        chk("b_one_frame_later", b_k - a_k, 32);
        wait_frames(2);

        load(40'h00_0000_0555, a_k);
        repeat (5) tick();
        chk("pend_before_rst", bcd_ready, 0);
        do_reset(2);
        wait_frames(2);

        load(40'h00_0000_3C21, a_k);
        wait_frames(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
